// File: rtl/p_s.sv
// p_s: parallel-to-serial stage.
// Takes the four 4-lane column words that follow each frame flag and un-transposes
// them into one half of a ping-pong frame buffer. Once a frame is complete it is
// replayed one sample per clock, in original sample order 0..15.
// The block also checks that frame flags arrive exactly FRAME_LEN cycles apart.
module p_s #(
  parameter int SAMPLE_W  = 34,
  parameter int FRAME_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_p_flag_in,
  input  logic [4*SAMPLE_W-1:0] data_in_1,
  output logic [SAMPLE_W-1:0]   data_out_1,
  output logic                  valid_out,
  output logic                  sof_out,
  output logic                  sync_err
);

  localparam logic [4:0] FRAME_LEN_C = 5'(FRAME_LEN);
  localparam logic [4:0] GAP_MAX     = 5'd31;

  typedef enum logic {
    IDLE,
    CAP
  } cap_state_t;

  cap_state_t          state;
  logic [1:0]          word_idx;
  logic                wr_buf;
  logic                rd_buf;
  logic                rd_active;
  logic [3:0]          rd_idx;
  logic [4:0]          gap_cnt;
  logic                armed;
  logic                cap_done;
  logic                abort;
  logic                spacing_bad;

  logic [SAMPLE_W-1:0] frame_mem [2][16];

  // The last column word is being written this cycle, so the frame is complete.
  assign cap_done = (state == CAP) && (word_idx == 2'd3);

  // A flag that arrives while the first three words are still coming in throws away
  // the partial frame.
  assign abort = (state == CAP) && (word_idx != 2'd3) && s_p_flag_in;

  // The gap counter reads exactly FRAME_LEN when the next flag is on time.
  assign spacing_bad = armed && (gap_cnt != FRAME_LEN_C);

  // Capture FSM. It steps through the column words, picks the write half of the
  // ping-pong buffer and tracks the spacing between flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_idx <= 2'd0;
      wr_buf   <= 1'b0;
      gap_cnt  <= 5'd0;
      armed    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= s_p_flag_in && (spacing_bad || abort);

      if (s_p_flag_in) begin
        gap_cnt <= 5'd1;
        armed   <= 1'b1;
      end else if (gap_cnt != GAP_MAX) begin
        gap_cnt <= gap_cnt + 5'd1;
      end

      case (state)
        IDLE: begin
          if (s_p_flag_in) begin
            state    <= CAP;
            word_idx <= 2'd0;
            wr_buf   <= ~rd_buf;
          end
        end
        CAP: begin
          if (abort) begin
            word_idx <= 2'd0;
          end else if (cap_done) begin
            if (s_p_flag_in) begin
              // The completed half becomes the read half, so the new capture
              // takes the other half.
              word_idx <= 2'd0;
              wr_buf   <= ~wr_buf;
            end else begin
              state <= IDLE;
            end
          end else begin
            word_idx <= word_idx + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame storage is not reset. Column word k, lane j holds sample 4*j+k.
  always_ff @(posedge clk) begin
    if (state == CAP) begin
      for (int j = 0; j < 4; j++) begin
        frame_mem[wr_buf][{j[1:0], word_idx}] <= data_in_1[j*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // Read side. A newly completed frame always takes over and starts at sample 0.
  // Otherwise the current frame is streamed to its end, and then the last sample is
  // held with valid low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_1 <= '0;
      valid_out  <= 1'b0;
      sof_out    <= 1'b0;
      rd_buf     <= 1'b0;
      rd_active  <= 1'b0;
      rd_idx     <= 4'd0;
    end else if (cap_done) begin
      data_out_1 <= frame_mem[wr_buf][0];
      valid_out  <= 1'b1;
      sof_out    <= 1'b1;
      rd_buf     <= wr_buf;
      rd_active  <= 1'b1;
      rd_idx     <= 4'd1;
    end else if (rd_active) begin
      data_out_1 <= frame_mem[rd_buf][rd_idx];
      valid_out  <= 1'b1;
      sof_out    <= 1'b0;
      rd_idx     <= rd_idx + 4'd1;
      if (rd_idx == 4'd15) begin
        rd_active <= 1'b0;
      end
    end else begin
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
    end
  end

endmodule
